// File: rtl/qpu_exu_wbck_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : qpu_exu_wbck_arb_if
//  Description : Bundle of the write-back arbiter's handshake and commit
//                buses.
//                  alu_wbck_i_*  : ALU result in (valid/ready, data, index,
//                                  rdwen, qwait)
//                  lng_wbck_i_*  : long-pipe write-back in (valid/ready,
//                                  data, index)
//                  rf_wbck_*     : classical register-file write port out
//                  time_wbck_*   : time-register write port out
//                  wbck_busy     : write-back activity flag out
//                The slave modport is the arbiter's view; the master modport
//                is the view of whatever drives the ALU/long-pipe inputs and
//                consumes the write ports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface qpu_exu_wbck_arb_if #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int TIME_W  = 20
);
    logic               alu_wbck_i_valid;
    logic               alu_wbck_i_ready;
    logic [XLEN-1:0]    alu_wbck_i_wdat;
    logic [RFIDX_W-1:0] alu_wbck_i_rdidx;
    logic               alu_wbck_i_rdwen;
    logic               alu_wbck_i_qwait;

    logic               lng_wbck_i_valid;
    logic               lng_wbck_i_ready;
    logic [XLEN-1:0]    lng_wbck_i_wdat;
    logic [RFIDX_W-1:0] lng_wbck_i_rdidx;

    logic               rf_wbck_ena;
    logic [RFIDX_W-1:0] rf_wbck_rdidx;
    logic [XLEN-1:0]    rf_wbck_wdat;

    logic               time_wbck_ena;
    logic [TIME_W-1:0]  time_wbck_wdat;

    logic               wbck_busy;

    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
               alu_wbck_i_rdwen, alu_wbck_i_qwait,
        output alu_wbck_i_ready,
        input  lng_wbck_i_valid, lng_wbck_i_wdat, lng_wbck_i_rdidx,
        output lng_wbck_i_ready,
        output rf_wbck_ena, rf_wbck_rdidx, rf_wbck_wdat,
        output time_wbck_ena, time_wbck_wdat,
        output wbck_busy
    );

    modport master (
        output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
               alu_wbck_i_rdwen, alu_wbck_i_qwait,
        input  alu_wbck_i_ready,
        output lng_wbck_i_valid, lng_wbck_i_wdat, lng_wbck_i_rdidx,
        input  lng_wbck_i_ready,
        input  rf_wbck_ena, rf_wbck_rdidx, rf_wbck_wdat,
        input  time_wbck_ena, time_wbck_wdat,
        input  wbck_busy
    );
endinterface
`default_nettype wire

// File: rtl/qpu_exu_wbck_arb.sv
`default_nettype none
// ============================================================================
//  Module      : qpu_exu_wbck_arb
//  Description : QPU EXU write-back stage behind the regular ALU. ALU results
//                are buffered in a DEPTH-entry FIFO and each is committed
//                either to the classical register file or, for QWAIT results,
//                to the time register. The single RF write port is shared
//                between the FIFO head and the long-pipe write-back; the long
//                pipe normally wins, but after STARVE_MAX consecutive losses
//                the FIFO head is forced through.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                bus    - qpu_exu_wbck_arb_if.slave (ALU in, long-pipe in,
//                         RF write port, time write port, busy flag)
//  Revision    : 1.0 - initial release
// ============================================================================
module qpu_exu_wbck_arb #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int TIME_W     = 20,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    qpu_exu_wbck_arb_if.slave    bus
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = $clog2(DEPTH + 1);
    localparam int c_STALL_W = $clog2(STARVE_MAX + 1);

    // FIFO storage (payload only, no reset needed: validity lives in r_count)
    logic [XLEN-1:0]    r_wdat  [DEPTH];
    logic [RFIDX_W-1:0] r_rdidx [DEPTH];
    logic               r_rdwen [DEPTH];
    logic               r_qwait [DEPTH];

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_STALL_W-1:0] r_stall_cnt;

    logic w_head_valid;
    logic w_head_qwait;
    logic w_alu_ready;
    logic w_push;
    logic w_pop;
    logic w_fifo_win;
    logic w_stall_sat;
    logic w_head_lost;

    // ------------------------------------------------------------------
    // Push side: no pass-through, a full FIFO refuses even if it pops now
    // ------------------------------------------------------------------
    assign w_alu_ready  = (r_count != c_CNT_W'(DEPTH));
    assign w_push       = bus.alu_wbck_i_valid & w_alu_ready;

    // ------------------------------------------------------------------
    // Head routing and RF-port arbitration
    // ------------------------------------------------------------------
    assign w_head_valid = (r_count != '0);
    assign w_head_qwait = w_head_valid & r_qwait[r_rd_ptr];
    assign w_stall_sat  = (r_stall_cnt == c_STALL_W'(STARVE_MAX));

    // A QWAIT head never touches the RF port, so it neither wins nor blocks
    // the long pipe; it pops on its own below.
    assign w_fifo_win   = w_head_valid & ~w_head_qwait
                        & (~bus.lng_wbck_i_valid | w_stall_sat);
    assign w_pop        = w_head_qwait | w_fifo_win;
    assign w_head_lost  = w_head_valid & ~w_head_qwait & ~w_fifo_win;

    always_comb begin
        bus.rf_wbck_ena   = 1'b0;
        bus.rf_wbck_rdidx = bus.lng_wbck_i_rdidx;
        bus.rf_wbck_wdat  = bus.lng_wbck_i_wdat;
        if (w_fifo_win) begin
            // Writes to x0 still consume the entry but raise no strobe
            bus.rf_wbck_ena   = r_rdwen[r_rd_ptr] & (r_rdidx[r_rd_ptr] != '0);
            bus.rf_wbck_rdidx = r_rdidx[r_rd_ptr];
            bus.rf_wbck_wdat  = r_wdat[r_rd_ptr];
        end else if (bus.lng_wbck_i_valid) begin
            bus.rf_wbck_ena   = (bus.lng_wbck_i_rdidx != '0);
        end
    end

    assign bus.alu_wbck_i_ready = w_alu_ready;
    assign bus.lng_wbck_i_ready = ~w_fifo_win;
    assign bus.time_wbck_ena    = w_head_qwait;
    // Only the low TIME_W bits of a QWAIT result are meaningful
    assign bus.time_wbck_wdat   = r_wdat[r_rd_ptr][TIME_W-1:0];
    assign bus.wbck_busy        = w_head_valid | bus.lng_wbck_i_valid;

    // ------------------------------------------------------------------
    // FIFO payload write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wdat[r_wr_ptr]  <= bus.alu_wbck_i_wdat;
            r_rdidx[r_wr_ptr] <= bus.alu_wbck_i_rdidx;
            r_rdwen[r_wr_ptr] <= bus.alu_wbck_i_rdwen;
            r_qwait[r_wr_ptr] <= bus.alu_wbck_i_qwait;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control and starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_stall_cnt <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

            if (w_pop || !w_head_valid) begin
                r_stall_cnt <= '0;
            end else if (w_head_lost && !w_stall_sat) begin
                r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qpu_exu_wbck_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qpu_exu_wbck_arb
//  Description : Self-checking bench for qpu_exu_wbck_arb. Directed stimulus
//                pushes the hand-computed sequence of register-file and
//                time-register commits into queues; a negedge monitor pops
//                and compares every strobe the DUT raises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qpu_exu_wbck_arb;

    localparam int c_XLEN    = 32;
    localparam int c_RFIDX_W = 5;
    localparam int c_TIME_W  = 20;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [c_RFIDX_W+c_XLEN-1:0] exp_rf   [$];
    logic [c_TIME_W-1:0]         exp_time [$];

    qpu_exu_wbck_arb_if #(
        .XLEN    (c_XLEN),
        .RFIDX_W (c_RFIDX_W),
        .TIME_W  (c_TIME_W)
    ) bus ();

    qpu_exu_wbck_arb #(
        .XLEN       (c_XLEN),
        .RFIDX_W    (c_RFIDX_W),
        .TIME_W     (c_TIME_W),
        .DEPTH      (2),
        .STARVE_MAX (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [31:0] d, input logic [4:0] idx,
                       input logic wen, input logic qw);
        bus.alu_wbck_i_valid = v;
        bus.alu_wbck_i_wdat  = d;
        bus.alu_wbck_i_rdidx = idx;
        bus.alu_wbck_i_rdwen = wen;
        bus.alu_wbck_i_qwait = qw;
    endtask

    task automatic lng(input logic v, input logic [4:0] idx, input logic [31:0] d);
        bus.lng_wbck_i_valid = v;
        bus.lng_wbck_i_rdidx = idx;
        bus.lng_wbck_i_wdat  = d;
    endtask

    task automatic exp_rf_push(input logic [4:0] idx, input logic [31:0] d);
        exp_rf.push_back({idx, d});
    endtask

    // Scoreboard monitor: every strobe must match the next expected commit
    always @(negedge clk) begin
        if (bus.rf_wbck_ena === 1'b1) begin
            n_checks++;
            if (exp_rf.size() == 0) begin
                n_fail++;
                $display("FAIL rf_write: unexpected write idx=%0d dat=0x%0h, none required",
                         bus.rf_wbck_rdidx, bus.rf_wbck_wdat);
            end else begin
                logic [c_RFIDX_W+c_XLEN-1:0] e;
                e = exp_rf.pop_front();
                if ({bus.rf_wbck_rdidx, bus.rf_wbck_wdat} !== e) begin
                    n_fail++;
                    $display("FAIL rf_write: got idx=%0d dat=0x%0h, required idx=%0d dat=0x%0h",
                             bus.rf_wbck_rdidx, bus.rf_wbck_wdat,
                             e[c_RFIDX_W+c_XLEN-1:c_XLEN], e[c_XLEN-1:0]);
                end
            end
        end
        if (bus.time_wbck_ena === 1'b1) begin
            n_checks++;
            if (exp_time.size() == 0) begin
                n_fail++;
                $display("FAIL time_write: unexpected write dat=0x%0h, none required",
                         bus.time_wbck_wdat);
            end else begin
                logic [c_TIME_W-1:0] t;
                t = exp_time.pop_front();
                if (bus.time_wbck_wdat !== t) begin
                    n_fail++;
                    $display("FAIL time_write: got 0x%0h, required 0x%0h",
                             bus.time_wbck_wdat, t);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        alu(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        lng(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        chk("reset_rf_ena",    64'(bus.rf_wbck_ena),      64'd0);
        chk("reset_time_ena",  64'(bus.time_wbck_ena),    64'd0);
        chk("reset_alu_ready", 64'(bus.alu_wbck_i_ready), 64'd1);
        chk("reset_busy",      64'(bus.wbck_busy),        64'd0);
        chk("reset_lng_ready", 64'(bus.lng_wbck_i_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // ---- single ALU push, commit one cycle later ----
        exp_rf_push(5'd5, 32'h0000_1234);
        alu(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0);
        chk("t1_alu_ready", 64'(bus.alu_wbck_i_ready), 64'd1);
        chk("t1_no_same_cycle_commit", 64'(bus.rf_wbck_ena), 64'd0);
        tick();
        alu(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        chk("t1_commit_ena", 64'(bus.rf_wbck_ena), 64'd1);
        chk("t1_busy", 64'(bus.wbck_busy), 64'd1);
        tick();
        chk("t1_idle_busy", 64'(bus.wbck_busy), 64'd0);

        // ---- QWAIT result to time register, concurrent long-pipe write ----
        exp_time.push_back(20'h00123);
        exp_rf_push(5'd7, 32'h0000_CAFE);
        alu(1'b1, 32'hFFF0_0123, 5'd3, 1'b0, 1'b1);
        tick();
        alu(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        lng(1'b1, 5'd7, 32'h0000_CAFE);
        chk("t2_time_ena", 64'(bus.time_wbck_ena), 64'd1);
        chk("t2_lng_ready", 64'(bus.lng_wbck_i_ready), 64'd1);
        tick();
        lng(1'b0, 5'd0, 32'h0);
        tick();

        // ---- starvation guard: long pipe wins 3 times, then FIFO forced ----
        exp_rf_push(5'd11, 32'h0000_1000);
        exp_rf_push(5'd11, 32'h0000_1001);
        exp_rf_push(5'd11, 32'h0000_1002);
        exp_rf_push(5'd11, 32'h0000_1003);
        exp_rf_push(5'd10, 32'h0000_00A0);
        exp_rf_push(5'd11, 32'h0000_1004);
        exp_rf_push(5'd12, 32'h0000_00B0);
        exp_rf_push(5'd13, 32'h0000_00C0);
        alu(1'b1, 32'h0000_00A0, 5'd10, 1'b1, 1'b0);
        lng(1'b1, 5'd11, 32'h0000_1000);
        tick();
        alu(1'b1, 32'h0000_00B0, 5'd12, 1'b1, 1'b0);
        lng(1'b1, 5'd11, 32'h0000_1001);
        chk("t3_ready_count1", 64'(bus.alu_wbck_i_ready), 64'd1);
        tick();
        alu(1'b1, 32'h0000_00C0, 5'd13, 1'b1, 1'b0);
        lng(1'b1, 5'd11, 32'h0000_1002);
        chk("t3_ready_full", 64'(bus.alu_wbck_i_ready), 64'd0);
        chk("t3_lng_win1", 64'(bus.lng_wbck_i_ready), 64'd1);
        tick();
        lng(1'b1, 5'd11, 32'h0000_1003);
        chk("t3_lng_win2", 64'(bus.lng_wbck_i_ready), 64'd1);
        tick();
        lng(1'b1, 5'd11, 32'h0000_1004);
        chk("t3_forced_lng_ready", 64'(bus.lng_wbck_i_ready), 64'd0);
        chk("t3_forced_alu_ready", 64'(bus.alu_wbck_i_ready), 64'd0);
        tick();
        chk("t3_ready_after_pop", 64'(bus.alu_wbck_i_ready), 64'd1);
        chk("t3_lng_after_pop", 64'(bus.lng_wbck_i_ready), 64'd1);
        tick();
        alu(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        lng(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        chk("t3_drained_busy", 64'(bus.wbck_busy), 64'd0);

        // ---- write to x0: slot consumed, no strobe ----
        alu(1'b1, 32'h0000_DEAD, 5'd0, 1'b1, 1'b0);
        tick();
        alu(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        chk("t4_x0_ena", 64'(bus.rf_wbck_ena), 64'd0);
        chk("t4_x0_busy", 64'(bus.wbck_busy), 64'd1);
        tick();
        chk("t4_x0_popped", 64'(bus.wbck_busy), 64'd0);

        // ---- full FIFO drains one per cycle, ready low for one cycle ----
        exp_rf_push(5'd11, 32'h0000_2000);
        exp_rf_push(5'd11, 32'h0000_2001);
        exp_rf_push(5'd1,  32'h0000_0051);
        exp_rf_push(5'd2,  32'h0000_0052);
        exp_rf_push(5'd3,  32'h0000_0053);
        alu(1'b1, 32'h0000_0051, 5'd1, 1'b1, 1'b0);
        lng(1'b1, 5'd11, 32'h0000_2000);
        tick();
        alu(1'b1, 32'h0000_0052, 5'd2, 1'b1, 1'b0);
        lng(1'b1, 5'd11, 32'h0000_2001);
        tick();
        alu(1'b1, 32'h0000_0053, 5'd3, 1'b1, 1'b0);
        lng(1'b0, 5'd0, 32'h0);
        chk("t5_full_ready", 64'(bus.alu_wbck_i_ready), 64'd0);
        tick();
        chk("t5_ready_back", 64'(bus.alu_wbck_i_ready), 64'd1);
        tick();
        alu(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        chk("t5_ready_stays", 64'(bus.alu_wbck_i_ready), 64'd1);
        tick();
        chk("t5_drained_busy", 64'(bus.wbck_busy), 64'd0);

        // ---- reset with two entries buffered: nothing stale is written ----
        exp_rf_push(5'd9, 32'h0000_3000);
        exp_rf_push(5'd9, 32'h0000_3001);
        alu(1'b1, 32'h0000_0061, 5'd20, 1'b1, 1'b0);
        lng(1'b1, 5'd9, 32'h0000_3000);
        tick();
        alu(1'b1, 32'h0000_0062, 5'd21, 1'b1, 1'b0);
        lng(1'b1, 5'd9, 32'h0000_3001);
        tick();
        alu(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        lng(1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rf_ena",    64'(bus.rf_wbck_ena),      64'd0);
        chk("t6_rst_time_ena",  64'(bus.time_wbck_ena),    64'd0);
        chk("t6_rst_alu_ready", 64'(bus.alu_wbck_i_ready), 64'd1);
        chk("t6_rst_busy",      64'(bus.wbck_busy),        64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_post_alu_ready", 64'(bus.alu_wbck_i_ready), 64'd1);
        chk("t6_post_busy",      64'(bus.wbck_busy),        64'd0);

        chk("rf_queue_empty",   64'(exp_rf.size()),   64'd0);
        chk("time_queue_empty", 64'(exp_time.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qpu_exu_wbck_arb.md
Name: qpu_exu_wbck_arb

Overview:
- Write-back stage directly downstream of the regular ALU in the QPU EXU.
- Buffers ALU results in a small FIFO, then commits each one to either the classical register file or the time register (QWAIT results).
- Arbitrates the single classical-RF write port between buffered ALU results and the long-pipe measurement write-back, with a starvation guard.

Parameters:
- XLEN, 32, data width of ALU result and RF write data.
- RFIDX_W, 5, classical register index width.
- TIME_W, 20, time register width; equals QPU_TIME_WIDTH.
- DEPTH, 2, ALU result FIFO entries; power of two, minimum 2.
- STARVE_MAX, 3, consecutive FIFO-head losses before the FIFO is forced to win.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_wbck_i_valid  in  1  ALU result valid.
- alu_wbck_i_ready  out  1  FIFO can accept.
- alu_wbck_i_wdat  in  XLEN  ALU result data.
- alu_wbck_i_rdidx  in  RFIDX_W  destination register index.
- alu_wbck_i_rdwen  in  1  result writes the classical RF.
- alu_wbck_i_qwait  in  1  result writes the time register instead.
- lng_wbck_i_valid  in  1  long-pipe write-back valid.
- lng_wbck_i_ready  out  1  long-pipe accepted this cycle.
- lng_wbck_i_wdat  in  XLEN  long-pipe data.
- lng_wbck_i_rdidx  in  RFIDX_W  long-pipe destination index.
- rf_wbck_ena  out  1  RF write strobe.
- rf_wbck_rdidx  out  RFIDX_W  RF write index.
- rf_wbck_wdat  out  XLEN  RF write data.
- time_wbck_ena  out  1  time register write strobe.
- time_wbck_wdat  out  TIME_W  time register write data.
- wbck_busy  out  1  FIFO non-empty or long-pipe valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: FIFO count, read and write pointers, and stall_cnt all 0.
- Outputs during and after reset: rf_wbck_ena=0, time_wbck_ena=0. wbck_busy=0 unless lng_wbck_i_valid=1. alu_wbck_i_ready=1.
- Reset mid-operation discards all buffered entries; no write strobe is asserted for them.
- Push:
  - alu_wbck_i_ready = (count != DEPTH). There is no same-cycle pass-through when full.
  - A handshake stores {wdat, rdidx, rdwen, qwait} at wr_ptr; the pointer wraps modulo DEPTH.
  - Entries with rdwen=0 and qwait=0 are still stored and popped, with no strobe.
- Latency: an ALU result is never committed in its accept cycle. Earliest commit is the cycle after the handshake. Long-pipe commit is combinational, in the same cycle as its handshake.
- Head routing. Head qwait=1:
  - Pops unconditionally; it does not use the RF port.
  - time_wbck_ena=1 and time_wbck_wdat = wdat[TIME_W-1:0]; upper bits are dropped.
  - If lng_wbck_i_valid=1 in the same cycle, lng also commits (lng_wbck_i_ready=1).
  - Does not advance stall_cnt.
- Head qwait=0: competes for the RF port.
  - fifo_win = head_valid & (~lng_wbck_i_valid | stall_cnt == STARVE_MAX).
  - lng_wbck_i_ready = ~fifo_win.
  - On fifo_win: pop. rf_wbck_ena = rdwen & (rdidx != 0). rdidx/wdat come from the head.
  - Otherwise, if lng_wbck_i_valid: rf_wbck_ena = (lng rdidx != 0), with lng data and index.
- Writes to x0 are suppressed (ena=0) but still consume their slot and handshake.
- stall_cnt:
  - Increments (saturating at STARVE_MAX) when a qwait=0 head loses to lng.
  - Clears on any pop or when the FIFO is empty.
  - Guarantees FIFO progress within STARVE_MAX+1 cycles.
- lng_wbck_i_ready=1 when the FIFO is empty.
- Simultaneous push and pop: count unchanged, both pointers advance. Full with pop: ready stays 0 that cycle and goes 1 the next cycle.
- rf_wbck_rdidx/wdat are don't-care when rf_wbck_ena=0. time_wbck_wdat is don't-care when time_wbck_ena=0.

Test Plan:
- Reset, then one ALU push (wdat=0x1234, rdidx=5, rdwen=1) at cycle 0 → cycle 1: rf_wbck_ena=1, rdidx=5, wdat=0x1234; cycle 2: wbck_busy=0.
- QWAIT push wdat=0xFFF00123 with TIME_W=20 → next cycle: time_wbck_ena=1, time_wbck_wdat=0x00123, rf_wbck_ena=0; a concurrent lng write (rdidx=7) commits in that same cycle.
- Hold alu_wbck_i_valid=1 with lng_wbck_i_valid=1 continuously → FIFO fills to 2, alu_wbck_i_ready=0; after 3 lng wins the FIFO head commits on the 4th contended cycle and lng_wbck_i_ready=0 in that cycle.
- ALU push with rdidx=0, rdwen=1 → popped next cycle with rf_wbck_ena=0; count returns to 0.
- Full FIFO, no lng traffic, push held → one pop per cycle; ready deasserted for exactly one cycle; data committed in order (A, B, C).
- Assert rst_n=0 with 2 entries buffered → strobes drop to 0 immediately; after release, no stale writes appear and alu_wbck_i_ready=1.
